// File: rtl/complex_addsub_arbiter.sv
// Round-robin arbiter sharing one packed complex add/sub datapath among NREQ requesters.
// Optional saturation of overflowing components is enabled by defining COMPLEX_ADDSUB_SAT_EN.
module complex_addsub_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = 2
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NREQ-1:0]      REQ_VALID,
  input  logic [NREQ-1:0]      REQ_OP,
  input  logic [32*NREQ-1:0]   REQ_A32,
  input  logic [32*NREQ-1:0]   REQ_B32,
  output logic [NREQ-1:0]      REQ_READY,
  output logic                 RES_VALID,
  input  logic                 RES_READY,
  output logic [31:0]          RES_R32,
  output logic [1:0]           RES_C_OUT32,
  output logic [1:0]           RES_OVF,
  output logic [ID_W-1:0]      RES_ID,
  output logic [15:0]          OP_COUNT
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic              res_valid_s;
  logic              accept_s;
  logic              transfer_s;
  logic              grant_found_s;
  logic [ID_W-1:0]   grant_id_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   ptr_next_s;
  logic [NREQ-1:0]   req_ready_s;
  logic [31:0]       op_a_s;
  logic [31:0]       op_b_s;
  logic              op_sub_s;
  logic [16:0]       sum_re_s;
  logic [16:0]       sum_im_s;
  logic [1:0]        ovf_s;
  logic [31:0]       result_s;
  logic [31:0]       res_r32_r;
  logic [1:0]        res_c_r;
  logic [1:0]        res_ovf_r;
  logic [ID_W-1:0]   res_id_r;
  logic [15:0]       op_count_r;

  // Subtraction is A + ~B + 1, so the carry-out doubles as the no-borrow flag.
  function automatic logic [16:0] addsub16(input logic [15:0] a, input logic [15:0] b,
                                           input logic sub);
    logic [15:0] b_eff;
    b_eff = sub ? ~b : b;
    return {1'b0, a} + {1'b0, b_eff} + {16'd0, sub};
  endfunction

  function automatic logic ovf16(input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] r, input logic sub);
    logic b_sign_eff;
    b_sign_eff = sub ? ~b[15] : b[15];
    return (a[15] == b_sign_eff) && (r[15] != a[15]);
  endfunction

`ifdef COMPLEX_ADDSUB_SAT_EN
  function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] r,
                                        input logic ovf);
    logic [15:0] res;
    if (!ovf) begin
      res = r;
    end else if (a[15]) begin
      res = 16'h8000;
    end else begin
      res = 16'h7FFF;
    end
    return res;
  endfunction
`endif

  // Accept path: output register is empty or being drained this cycle.
  always_comb begin
    accept_s = ~res_valid_s | RES_READY;
  end

  // Round-robin scan starting at the priority pointer.
  always_comb begin
    int idx;
    idx           = 0;
    grant_found_s = 1'b0;
    grant_id_s    = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_r) + k;
      if (idx >= NREQ) begin
        idx = idx - NREQ;
      end else begin
        idx = idx;
      end
      if (!grant_found_s && REQ_VALID[idx]) begin
        grant_found_s = 1'b1;
        grant_id_s    = ID_W'(idx);
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // One-hot ready, suppressed during reset or when the result register cannot take a result.
  always_comb begin
    if (RST_N && accept_s && grant_found_s) begin
      req_ready_s = {{(NREQ-1){1'b0}}, 1'b1} << grant_id_s;
    end else begin
      req_ready_s = '0;
    end
    transfer_s = |req_ready_s;
  end

  // Pointer moves to the slot after the winner, wrapping at NREQ-1.
  always_comb begin
    if (grant_id_s == ID_W'(NREQ - 1)) begin
      ptr_next_s = '0;
    end else begin
      ptr_next_s = grant_id_s + {{(ID_W-1){1'b0}}, 1'b1};
    end
  end

  // Operand mux and per-component arithmetic for the granted requester.
  always_comb begin
    op_a_s    = REQ_A32[32*grant_id_s +: 32];
    op_b_s    = REQ_B32[32*grant_id_s +: 32];
    op_sub_s  = REQ_OP[grant_id_s];
    sum_re_s  = addsub16(op_a_s[31:16], op_b_s[31:16], op_sub_s);
    sum_im_s  = addsub16(op_a_s[15:0],  op_b_s[15:0],  op_sub_s);
    ovf_s[1]  = ovf16(op_a_s[31:16], op_b_s[31:16], sum_re_s[15:0], op_sub_s);
    ovf_s[0]  = ovf16(op_a_s[15:0],  op_b_s[15:0],  sum_im_s[15:0], op_sub_s);
`ifdef COMPLEX_ADDSUB_SAT_EN
    result_s  = {sat16(op_a_s[31:16], sum_re_s[15:0], ovf_s[1]),
                 sat16(op_a_s[15:0],  sum_im_s[15:0], ovf_s[0])};
`else
    result_s  = {sum_re_s[15:0], sum_im_s[15:0]};
`endif
  end

  // Control state register.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Control next-state logic.
  always_comb begin
    case (state_r)
      ST_EMPTY: begin
        if (transfer_s) begin
          state_next_s = ST_FULL;
        end else begin
          state_next_s = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (transfer_s) begin
          state_next_s = ST_FULL;
        end else if (RES_READY) begin
          state_next_s = ST_EMPTY;
        end else begin
          state_next_s = ST_FULL;
        end
      end
      default: state_next_s = ST_EMPTY;
    endcase
  end

  // Control outputs decoded from the state register.
  always_comb begin
    case (state_r)
      ST_FULL:  res_valid_s = 1'b1;
      ST_EMPTY: res_valid_s = 1'b0;
      default:  res_valid_s = 1'b0;
    endcase
  end

  // Result register, pointer and completion counter; held when nothing transfers.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      res_r32_r  <= 32'h0000_0000;
      res_c_r    <= 2'b00;
      res_ovf_r  <= 2'b00;
      res_id_r   <= '0;
      op_count_r <= 16'h0000;
      ptr_r      <= '0;
    end else if (transfer_s) begin
      res_r32_r  <= result_s;
      res_c_r    <= {sum_re_s[16], sum_im_s[16]};
      res_ovf_r  <= ovf_s;
      res_id_r   <= grant_id_s;
      op_count_r <= op_count_r + 16'd1;
      ptr_r      <= ptr_next_s;
    end else begin
      res_r32_r  <= res_r32_r;
      res_c_r    <= res_c_r;
      res_ovf_r  <= res_ovf_r;
      res_id_r   <= res_id_r;
      op_count_r <= op_count_r;
      ptr_r      <= ptr_r;
    end
  end

  assign REQ_READY   = req_ready_s;
  assign RES_VALID   = res_valid_s;
  assign RES_R32     = res_r32_r;
  assign RES_C_OUT32 = res_c_r;
  assign RES_OVF     = res_ovf_r;
  assign RES_ID      = res_id_r;
  assign OP_COUNT    = op_count_r;

endmodule

// File: tb/tb_complex_addsub_arbiter.sv
// Randomized self-checking bench for complex_addsub_arbiter against an arithmetic reference model.
module tb_complex_addsub_arbiter;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_op;
  logic [32*NREQ-1:0]  req_a32;
  logic [32*NREQ-1:0]  req_b32;
  logic [NREQ-1:0]     req_ready;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_r32;
  logic [1:0]          res_c_out32;
  logic [1:0]          res_ovf;
  logic [ID_W-1:0]     res_id;
  logic [15:0]         op_count;

  int checks;
  int errors;

  // Reference model state
  bit          m_valid;
  logic [31:0] m_r;
  logic [1:0]  m_c;
  logic [1:0]  m_ovf;
  int          m_id;
  int          m_cnt;
  int          m_ptr;

  complex_addsub_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .CLK(clk), .RST_N(rst_n), .REQ_VALID(req_valid), .REQ_OP(req_op),
    .REQ_A32(req_a32), .REQ_B32(req_b32), .REQ_READY(req_ready),
    .RES_VALID(res_valid), .RES_READY(res_ready), .RES_R32(res_r32),
    .RES_C_OUT32(res_c_out32), .RES_OVF(res_ovf), .RES_ID(res_id),
    .OP_COUNT(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Plain integer arithmetic per component, signed range test for overflow.
  task automatic ref_calc(input logic [31:0] a, input logic [31:0] b, input logic sub,
                          output logic [31:0] r, output logic [1:0] c, output logic [1:0] ovf);
    for (int h = 0; h < 2; h++) begin
      int ua, ub, sa, sb, ss, res;
      ua = int'(a[16*h +: 16]);
      ub = int'(b[16*h +: 16]);
      sa = (ua >= 32768) ? ua - 65536 : ua;
      sb = (ub >= 32768) ? ub - 65536 : ub;
      if (!sub) begin
        c[h] = (ua + ub) > 65535;
        res  = (ua + ub) % 65536;
        ss   = sa + sb;
      end else begin
        c[h] = (ua >= ub);
        res  = (ua - ub + 65536) % 65536;
        ss   = sa - sb;
      end
      ovf[h] = (ss > 32767) || (ss < -32768);
`ifdef COMPLEX_ADDSUB_SAT_EN
      if (ovf[h]) res = (sa >= 0) ? 32767 : 32768;
`endif
      r[16*h +: 16] = 16'(res);
    end
  endtask

  // One clock: check ready against the model, advance the model, check registered outputs.
  task automatic tick();
    logic [NREQ-1:0] exp_ready;
    logic [31:0]     r;
    logic [1:0]      c, o;
    int              g;
    bit              acc;
    #1;
    acc = !m_valid || res_ready;
    g = -1;
    exp_ready = '0;
    if (rst_n && acc) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
      if (g >= 0) exp_ready[g] = 1'b1;
    end
    check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
    if (!rst_n) begin
      m_valid = 0; m_r = '0; m_c = '0; m_ovf = '0; m_id = 0; m_cnt = 0; m_ptr = 0;
    end else if (g >= 0) begin
      ref_calc(req_a32[32*g +: 32], req_b32[32*g +: 32], req_op[g], r, c, o);
      m_valid = 1; m_r = r; m_c = c; m_ovf = o; m_id = g;
      m_cnt = (m_cnt + 1) % 65536;
      m_ptr = (g + 1) % NREQ;
    end else if (res_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    check_eq("res_valid", 32'(res_valid), 32'(m_valid));
    check_eq("res_r32", res_r32, m_r);
    check_eq("res_c_out32", 32'(res_c_out32), 32'(m_c));
    check_eq("res_ovf", 32'(res_ovf), 32'(m_ovf));
    check_eq("res_id", 32'(res_id), 32'(m_id));
    check_eq("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  function automatic logic [15:0] rand16();
    case ($urandom_range(0, 5))
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic randomize_operands();
    for (int i = 0; i < NREQ; i++) begin
      req_a32[32*i +: 32] = {rand16(), rand16()};
      req_b32[32*i +: 32] = {rand16(), rand16()};
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] sat_exp;
    checks = 0; errors = 0;
    m_valid = 0; m_r = '0; m_c = '0; m_ovf = '0; m_id = 0; m_cnt = 0; m_ptr = 0;
    rst_n = 1'b0; req_valid = '0; req_op = '0; req_a32 = '0; req_b32 = '0; res_ready = 1'b1;
    do_reset();
    check_eq("reset_valid", 32'(res_valid), 32'd0);
    check_eq("reset_count", 32'(op_count), 32'd0);

    // Requester 0 subtract
    req_a32[31:0] = 32'h0005_0003; req_b32[31:0] = 32'h0002_0007;
    req_op = 4'b0001; req_valid = 4'b0001;
    tick();
    check_eq("sub_r32", res_r32, 32'h0003_FFFC);
    check_eq("sub_c", 32'(res_c_out32), 32'd2);
    check_eq("sub_ovf", 32'(res_ovf), 32'd0);
    check_eq("sub_id", 32'(res_id), 32'd0);
    check_eq("sub_count", 32'(op_count), 32'd1);

    // Requester 1 add with real overflow
    req_a32[63:32] = 32'h7FFF_0001; req_b32[63:32] = 32'h0001_0001;
    req_op = 4'b0000; req_valid = 4'b0010;
    tick();
`ifdef COMPLEX_ADDSUB_SAT_EN
    sat_exp = 32'h7FFF_0002;
`else
    sat_exp = 32'h8000_0002;
`endif
    check_eq("add_r32", res_r32, sat_exp);
    check_eq("add_ovf", 32'(res_ovf), 32'd2);

    // Round robin with all requesters valid
    do_reset();
    randomize_operands();
    req_valid = 4'b1111; req_op = 4'b1010;
    for (int s = 0; s < 5; s++) begin
      tick();
      check_eq("rr_id", 32'(res_id), 32'(s % NREQ));
    end
    check_eq("rr_count", 32'(op_count), 32'd5);

    // Back-pressure hold then same-cycle refill
    res_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      randomize_operands();
      tick();
      check_eq("hold_id", 32'(res_id), 32'd0);
      check_eq("hold_count", 32'(op_count), 32'd5);
    end
    res_ready = 1'b1;
    tick();
    check_eq("refill_valid", 32'(res_valid), 32'd1);
    check_eq("refill_id", 32'(res_id), 32'd1);

    // Drive pointer to 3, then wrap scan to requester 1
    req_valid = 4'b0100;
    tick();
    req_valid = 4'b0010;
    tick();
    check_eq("wrap_id", 32'(res_id), 32'd1);
    req_valid = 4'b1111;
    tick();
    check_eq("wrap_next_id", 32'(res_id), 32'd2);

    // Reset while full with requests pending
    res_ready = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("rst_full_valid", 32'(res_valid), 32'd0);
    check_eq("rst_full_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    res_ready = 1'b1;
    tick();
    check_eq("rst_ptr_id", 32'(res_id), 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      randomize_operands();
      req_valid = 4'($urandom);
      req_op    = 4'($urandom);
      res_ready = ($urandom_range(0, 9) < 7);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
